// File: rtl/alu_rr_scheduler.sv
// Round-robin front end for one shared 64-bit ALU: picks one requester per cycle,
// computes its operation combinationally and holds the result in a one-entry register.
module alu_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    input  logic [3*NREQ-1:0]    req_op,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [63:0]          resp_data,
    output logic [IDW-1:0]       resp_id,
    output logic                 busy
);
    localparam int DATA_W = 64;
    localparam int OPW    = 3;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   resp_data_p1_q;
    logic [IDW-1:0]      resp_id_p1_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [IDW-1:0]      rr_ptr_d;

    logic                slot_free;
    logic                hi_found;
    logic                lo_found;
    logic [IDW-1:0]      hi_idx;
    logic [IDW-1:0]      lo_idx;
    logic                gnt_found;
    logic [IDW-1:0]      gnt_idx;
    logic                transfer;
    logic [DATA_W-1:0]   a_sel;
    logic [DATA_W-1:0]   b_sel;
    logic [OPW-1:0]      op_sel;
    logic [DATA_W-1:0]   alu_res;

    // Arithmetic wraps modulo 2^64, so carries and borrows simply fall off the top.
    function automatic logic [DATA_W-1:0] alu_f(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [OPW-1:0]    op
    );
        logic [DATA_W-1:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = b - a;
            3'b011:  r = a | b;
            3'b100:  r = a & b;
            3'b101:  r = a ^ b;
            3'b110:  r = ~(a ^ b);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign resp_valid = (state_q == FULL);
    assign resp_data  = resp_data_p1_q;
    assign resp_id    = resp_id_p1_q;
    assign busy       = (|req_valid) || resp_valid;
    assign slot_free  = !resp_valid || resp_ready;

    // Lowest valid index at/after the pointer wins; otherwise wrap to the lowest valid overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDW'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end
            end
        end
        gnt_found = (hi_found || lo_found) && slot_free && !rst;
        gnt_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign req_ready = gnt_found ? (NREQ'(1) << gnt_idx) : '0;
    assign transfer  = |(req_valid & req_ready);
    assign rr_ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                a_sel  = req_a[DATA_W*i +: DATA_W];
                b_sel  = req_b[DATA_W*i +: DATA_W];
                op_sel = req_op[OPW*i +: OPW];
            end
        end
    end

    assign alu_res = alu_f(a_sel, b_sel, op_sel);

    // ---- stage p1: result register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= EMPTY;
            resp_data_p1_q <= '0;
            resp_id_p1_q   <= '0;
            rr_ptr_q       <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (transfer) state_q <= FULL;
                end
                FULL: begin
                    if (resp_ready && !transfer) state_q <= EMPTY;
                end
                default: state_q <= EMPTY;
            endcase
            if (transfer) begin
                resp_data_p1_q <= alu_res;
                resp_id_p1_q   <= gnt_idx;
                rr_ptr_q       <= rr_ptr_d;
            end
        end
    end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: a cycle model with a result scoreboard runs on every
// falling edge, alongside table-driven ALU vectors and directed arbitration sequences.
module tb_alu_rr_scheduler;
    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [64*NREQ-1:0]  req_a;
    logic [64*NREQ-1:0]  req_b;
    logic [3*NREQ-1:0]   req_op;
    logic                resp_valid;
    logic                resp_ready;
    logic [63:0]         resp_data;
    logic [IDW-1:0]      resp_id;
    logic                busy;

    alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit en_mon = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] alu_ref(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return b - a;
            3'd3: return a | b;
            3'd4: return a & b;
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return 64'd0;
        endcase
    endfunction

    typedef struct {
        logic [63:0] d;
        logic [2:0]  id;
    } sb_t;
    sb_t sbq[$];

    // Reference model state, advanced once per falling edge to predict the next rising edge.
    bit          m_vld = 1'b0;
    int          m_ptr = 0;
    bit          m_found;
    int          m_g;
    logic [3:0]  m_er;
    sb_t         m_e;
    sb_t         m_new;

    always @(negedge clk) begin
        if (en_mon) begin
            m_found = 1'b0;
            m_g     = 0;
            m_er    = '0;
            if (!rst && (!m_vld || resp_ready)) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!m_found && req_valid[(m_ptr + k) % NREQ]) begin
                        m_found = 1'b1;
                        m_g     = (m_ptr + k) % NREQ;
                    end
                end
            end
            if (m_found) m_er = 4'b0001 << m_g;
            check("sb_req_ready", {60'd0, req_ready}, {60'd0, m_er});
            check("sb_busy", {63'd0, busy}, {63'd0, (|req_valid) || m_vld});
            check("sb_resp_valid", {63'd0, resp_valid}, {63'd0, m_vld});
            if (rst) begin
                sbq.delete();
                m_vld = 1'b0;
                m_ptr = 0;
            end else begin
                if (resp_valid && resp_ready) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_pop: result id %0d with no expected entry", resp_id);
                    end else begin
                        m_e = sbq.pop_front();
                        check("sb_resp_data", resp_data, m_e.d);
                        check("sb_resp_id", {61'd0, resp_id}, {61'd0, m_e.id});
                    end
                end
                if (m_found) begin
                    m_new.d  = alu_ref(req_a[64*m_g +: 64], req_b[64*m_g +: 64], req_op[3*m_g +: 3]);
                    m_new.id = 3'(m_g);
                    sbq.push_back(m_new);
                    m_vld = 1'b1;
                    m_ptr = (m_g + 1) % NREQ;
                end else if (m_vld && resp_ready) begin
                    m_vld = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  op;
        logic [63:0] exp;
    } vec_t;
    vec_t vt[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
        req_op[3*i +: 3]  = op;
    endtask

    task automatic do_reset();
        tick();
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{64'd1, 64'd0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, 64'd0};
        vt[2] = '{64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[3] = '{64'd123, 64'd456, 3'b111, 64'd0};
        vt[4] = '{64'hF0, 64'h0F, 3'b011, 64'hFF};
        vt[5] = '{64'hFF00, 64'h0FF0, 3'b100, 64'h0F00};
        vt[6] = '{64'hFF, 64'h0F, 3'b101, 64'hF0};
        vt[7] = '{64'd0, 64'd1, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b000, 64'd0};
        vt[9] = '{64'd10, 64'd25, 3'b010, 64'd15};

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en_mon    = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        check("rst_req_ready", {60'd0, req_ready}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_resp_id", {61'd0, resp_id}, 64'd0);
        tick();

        // Reset release, req0 subtract
        rst        = 1'b0;
        resp_ready = 1'b1;
        req_valid  = 4'b0001;
        set_req(0, 64'd5, 64'd3, 3'b001);
        @(negedge clk);
        check("t1_req_ready", {60'd0, req_ready}, 64'h1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t1_resp_valid", {63'd0, resp_valid}, 64'd1);
        check("t1_resp_data", resp_data, 64'd2);
        check("t1_resp_id", {61'd0, resp_id}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            tick();
            set_req(0, vt[i].a, vt[i].b, vt[i].op);
            req_valid = 4'b0001;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), {60'd0, req_ready}, 64'h1);
            tick();
            req_valid = '0;
            @(negedge clk);
            check($sformatf("vec%0d_data", i), resp_data, vt[i].exp);
        end

        // Round robin with all four requesting continuously
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 64'(100 * (i + 1)), 64'(i), 3'b000);
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("rr%0d_ready", k), {60'd0, req_ready}, 64'(1 << (k % 4)));
            if (k > 0) begin
                check($sformatf("rr%0d_valid", k), {63'd0, resp_valid}, 64'd1);
                check($sformatf("rr%0d_id", k), {61'd0, resp_id}, 64'((k - 1) % 4));
                check($sformatf("rr%0d_data", k), resp_data, 64'(100 * ((k - 1) % 4 + 1) + (k - 1) % 4));
            end
            tick();
        end
        req_valid = '0;

        // Backpressure stall then release
        do_reset();
        resp_ready = 1'b0;
        set_req(0, 64'd7, 64'd2, 3'b001);
        req_valid = 4'b0001;
        @(negedge clk);
        check("st_first_ready", {60'd0, req_ready}, 64'h1);
        tick();
        set_req(1, 64'd10, 64'd3, 3'b000);
        set_req(2, 64'd6, 64'd4, 3'b010);
        req_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("st%0d_ready", k), {60'd0, req_ready}, 64'd0);
            check($sformatf("st%0d_valid", k), {63'd0, resp_valid}, 64'd1);
            check($sformatf("st%0d_data", k), resp_data, 64'd5);
            check($sformatf("st%0d_id", k), {61'd0, resp_id}, 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("rel_ready_req1", {60'd0, req_ready}, 64'h2);
        check("rel_data_old", resp_data, 64'd5);
        tick();
        req_valid = 4'b0100;
        @(negedge clk);
        check("rel_ready_req2", {60'd0, req_ready}, 64'h4);
        check("rel_id1", {61'd0, resp_id}, 64'd1);
        check("rel_data1", resp_data, 64'd13);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("rel_id2", {61'd0, resp_id}, 64'd2);
        check("rel_data2", resp_data, 64'hFFFF_FFFF_FFFF_FFFE);

        // Reset in the middle of traffic
        tick();
        for (int i = 0; i < NREQ; i++) set_req(i, 64'(i + 1), 64'h30, 3'b011);
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mr_ready_in_rst", {60'd0, req_ready}, 64'd0);
        tick();
        @(negedge clk);
        check("mr_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("mr_resp_data", resp_data, 64'd0);
        check("mr_resp_id", {61'd0, resp_id}, 64'd0);
        check("mr_ready", {60'd0, req_ready}, 64'd0);
        tick();
        rst        = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("mr_first_grant", {60'd0, req_ready}, 64'h1);
        tick();
        req_valid = '0;

        // Lone requester at the top index: pointer wraps, no dead cycle
        set_req(3, 64'hF0F0, 64'hFF00, 3'b100);
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("wr%0d_ready", k), {60'd0, req_ready}, 64'h8);
            if (k > 0) begin
                check($sformatf("wr%0d_id", k), {61'd0, resp_id}, 64'd3);
                check($sformatf("wr%0d_data", k), resp_data, 64'hF000);
            end
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        check("wr_last_valid", {63'd0, resp_valid}, 64'd1);
        check("wr_last_id", {61'd0, resp_id}, 64'd3);
        tick();
        @(negedge clk);
        check("wr_drained", {63'd0, resp_valid}, 64'd0);
        check("wr_idle_busy", {63'd0, busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
